event_indicator: RTL

//   Output-side counterpart of the button debouncer. It turns single-cycle event pulses
//   (debounced presses, entry/exit events) into human-visible, timed blinks on an LED or

---
 rtl/parking_pkg.sv | 19 +
 rtl/cycle_timer.sv | 31 +++
 rtl/event_indicator.sv | 131 +++++++++++++
 3 files changed

// File: rtl/parking_pkg.sv
// Shared definitions for the parking UI blocks (debouncer, event indicator):
// clock rate, default human-visible timing and the indicator state encoding.
package parking_pkg;

    localparam int unsigned CLK_HZ            = 40_000_000;
    // 200 ms at CLK_HZ; the debouncer uses the same settle time.
    localparam int unsigned DEFAULT_UI_CYCLES = CLK_HZ / 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_GAP  = 2'd2
    } ind_state_t;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/cycle_timer.sv
// Interval timer: counts up from zero while run is high and raises expire in
// the cycle where the count reaches term_value (interval = term_value + 1
// cycles). The count returns to zero on expire or restart, so every new
// interval starts cleanly.
module cycle_timer #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         restart,
    input  logic         run,
    input  logic [W-1:0] term_value,
    output logic         expire
);

    logic [W-1:0] count;

    assign expire = run && (count == term_value);

    // interval counter, cleared on expire/restart so each interval begins at zero
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (restart || expire) begin
            count <= '0;
        end else if (run) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/event_indicator.sv
// Turns single-cycle event pulses into timed blinks with an off-gap between
// them; events arriving during a blink are queued in a saturating counter.
//
//   state   | meaning
//   --------+----------------------------------------------------------
//   IDLE    | nothing to show, led off, waiting for an event
//   ON      | blink in progress, led on for ON_CYCLES
//   GAP     | mandatory led-off gap of OFF_CYCLES after every blink
module event_indicator
    import parking_pkg::*;
#(
    parameter int unsigned ON_CYCLES   = DEFAULT_UI_CYCLES,
    parameter int unsigned OFF_CYCLES  = DEFAULT_UI_CYCLES,
    parameter int unsigned MAX_PENDING = 7,
    localparam int unsigned PW         = $clog2(MAX_PENDING + 1)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          pulse_in,
    input  logic          clear,
    output logic          led_out,
    output logic          busy,
    output logic [PW-1:0] pending,
    output logic          overflow
);

    localparam int unsigned   CW       = $clog2(max_u(ON_CYCLES, OFF_CYCLES) + 1);
    localparam logic [CW-1:0] ON_TERM  = CW'(ON_CYCLES - 1);
    localparam logic [CW-1:0] OFF_TERM = CW'(OFF_CYCLES - 1);
    localparam logic [PW-1:0] PEND_MAX = PW'(MAX_PENDING);

    ind_state_t    state;
    ind_state_t    state_next;
    logic          timer_run;
    logic [CW-1:0] timer_term;
    logic          timer_expire;
    logic          has_pending;
    logic          gap_end;
    logic          enq;
    logic          deq;
    logic [PW-1:0] pending_next;
    logic          overflow_next;
    logic          led_next;
    logic          busy_next;

    assign timer_run   = (state != ST_IDLE);
    assign timer_term  = (state == ST_ON) ? ON_TERM : OFF_TERM;
    assign has_pending = (pending != '0);
    assign gap_end     = (state == ST_GAP) && timer_expire;

    cycle_timer #(
        .W (CW)
    ) u_timer (
        .clk        (clk),
        .reset_n    (reset_n),
        .restart    (clear),
        .run        (timer_run),
        .term_value (timer_term),
        .expire     (timer_expire)
    );

    // state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // next-state decision; clear overrides everything
    always_comb begin
        state_next = state;
        if (clear) begin
            state_next = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (pulse_in || has_pending) state_next = ST_ON;
                ST_ON:   if (timer_expire) state_next = ST_GAP;
                ST_GAP:  if (timer_expire) state_next = (has_pending || pulse_in) ? ST_ON : ST_IDLE;
                default: state_next = ST_IDLE;
            endcase
        end
    end

    // output decode from the next state so led/busy register in step with state
    always_comb begin
        led_next  = (state_next == ST_ON);
        busy_next = (state_next != ST_IDLE);
    end

    // queue bookkeeping: a pulse that starts a blink directly (IDLE, or GAP end
    // with an empty queue) is never queued; at GAP end with a non-empty queue the
    // oldest event starts and a simultaneous pulse takes its slot
    always_comb begin
        deq = !clear && has_pending && (((state == ST_IDLE) && !pulse_in) || gap_end);
        enq = !clear && pulse_in &&
              ((state == ST_ON) || ((state == ST_GAP) && (!gap_end || has_pending)));
        pending_next  = pending;
        overflow_next = 1'b0;
        if (clear) begin
            pending_next = '0;
        end else if (enq && deq) begin
            pending_next = pending;
        end else if (enq) begin
            if (pending == PEND_MAX) begin
                overflow_next = 1'b1;
            end else begin
                pending_next = pending + PW'(1);
            end
        end else if (deq) begin
            pending_next = pending - PW'(1);
        end
    end

    // registered outputs and queue depth
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            led_out  <= 1'b0;
            busy     <= 1'b0;
            pending  <= '0;
            overflow <= 1'b0;
        end else begin
            led_out  <= led_next;
            busy     <= busy_next;
            pending  <= pending_next;
            overflow <= overflow_next;
        end
    end

endmodule
